// File: rtl/rgb_batch_fifo.sv
// rgb_batch_fifo: de-interleaves RGB pixels into per-channel batches held in a
// DEPTH-slot FIFO. A flush rising edge closes a partial batch with padding.
module rgb_batch_fifo #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned BATCH_SIZE  = 8,
  parameter int unsigned DEPTH       = 4,
  parameter logic [COLOR_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                                         I_rgb_clk,
  input  logic                                         I_rst_n,
  input  logic                                         I_flush,
  input  logic [CHANNELS*COLOR_WIDTH-1:0]              I_pixel,
  input  logic                                         I_pixel_valid,
  output logic                                         O_pixel_ready,
  output logic                                         O_batch_valid,
  input  logic                                         I_batch_ready,
  output logic [CHANNELS*BATCH_SIZE*COLOR_WIDTH-1:0]   O_batch_data,
  output logic [$clog2(BATCH_SIZE+1)-1:0]              O_batch_fill,
  output logic [$clog2(DEPTH+1)-1:0]                   O_level,
  output logic                                         O_overflow,
  input  logic                                         I_clear_overflow
);

  localparam int unsigned IdxW  = $clog2(BATCH_SIZE);
  localparam int unsigned FillW = $clog2(BATCH_SIZE + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BATCH_SIZE - 1);

  logic [IdxW-1:0]        elem_q, elem_d;
  logic [PtrW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   flush_q;
  logic                   ovf_q, ovf_d;
  logic [FillW-1:0]       fill_q [DEPTH];
  logic [COLOR_WIDTH-1:0] mem_q [DEPTH][CHANNELS][BATCH_SIZE];

  logic             accept, flush_edge, last_elem, pad_en, commit, pop;
  logic [FillW-1:0] commit_fill;
  int               pad_from;

  assign O_pixel_ready = (count_q < CntW'(DEPTH));
  assign O_batch_valid = (count_q != '0);
  assign O_level       = count_q;
  assign O_overflow    = ovf_q;

  // Handshake decode and next-state for pointers, counters and flags.
  always_comb begin
    accept      = I_pixel_valid & O_pixel_ready;
    flush_edge  = I_flush & ~flush_q;
    last_elem   = (elem_q == LastIdx);
    // A flush only pads when something real is in the batch and the accept
    // (if any) has not already completed it.
    pad_en      = flush_edge & (accept ? ~last_elem : (elem_q != '0));
    commit      = (accept & last_elem) | pad_en;
    commit_fill = accept ? (FillW'(elem_q) + FillW'(1)) : FillW'(elem_q);
    pad_from    = int'(elem_q) + (accept ? 1 : 0);
    pop         = O_batch_valid & I_batch_ready;

    elem_d  = elem_q;
    if (commit) begin
      elem_d = '0;
    end else if (accept) begin
      elem_d = elem_q + IdxW'(1);
    end
    wr_d    = commit ? wr_q + PtrW'(1) : wr_q;
    rd_d    = pop ? rd_q + PtrW'(1) : rd_q;
    count_d = count_q + CntW'(commit) - CntW'(pop);

    ovf_d = ovf_q;
    if (I_pixel_valid && !O_pixel_ready) begin
      ovf_d = 1'b1;
    end else if (I_clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  // Control state and per-slot fill counts.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      elem_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int s = 0; s < int'(DEPTH); s++) begin
        fill_q[s] <= '0;
      end
    end else begin
      elem_q  <= elem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      flush_q <= I_flush;
      ovf_q   <= ovf_d;
      if (commit) begin
        fill_q[wr_q] <= commit_fill;
      end
    end
  end

  // Element storage: pixel write at elem_idx, pad fill above it on flush.
  always_ff @(posedge I_rgb_clk) begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      for (int i = 0; i < int'(BATCH_SIZE); i++) begin
        if (accept && (i == int'(elem_q))) begin
          mem_q[wr_q][c][i] <= I_pixel[c*COLOR_WIDTH +: COLOR_WIDTH];
        end else if (pad_en && (i >= pad_from)) begin
          mem_q[wr_q][c][i] <= PAD_VALUE;
        end
      end
    end
  end

  // Head batch view; zeroed when the FIFO is empty.
  always_comb begin
    O_batch_data = '0;
    O_batch_fill = '0;
    if (O_batch_valid) begin
      O_batch_fill = fill_q[rd_q];
      for (int c = 0; c < int'(CHANNELS); c++) begin
        for (int i = 0; i < int'(BATCH_SIZE); i++) begin
          O_batch_data[(c*BATCH_SIZE+i)*COLOR_WIDTH +: COLOR_WIDTH] = mem_q[rd_q][c][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_batch_fifo.sv
// Self-checking bench for rgb_batch_fifo: queue-based reference model compared
// every cycle, plus directed literal expectations.
module tb_rgb_batch_fifo;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int BS = 8;
  localparam int DP = 4;
  localparam logic [7:0] PAD = 8'h00;
  localparam int DW = CH * BS * CW;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [23:0]   pixel;
  logic          pvalid;
  logic          pready;
  logic          bvalid;
  logic          bready;
  logic [DW-1:0] bdata;
  logic [3:0]    bfill;
  logic [2:0]    level;
  logic          ovf;
  logic          clr;

  int checks = 0;
  int errors = 0;

  rgb_batch_fifo #(
    .CHANNELS(CH), .COLOR_WIDTH(CW), .BATCH_SIZE(BS), .DEPTH(DP), .PAD_VALUE(PAD)
  ) dut (
    .I_rgb_clk(clk),
    .I_rst_n(rst_n),
    .I_flush(flush),
    .I_pixel(pixel),
    .I_pixel_valid(pvalid),
    .O_pixel_ready(pready),
    .O_batch_valid(bvalid),
    .I_batch_ready(bready),
    .O_batch_data(bdata),
    .O_batch_fill(bfill),
    .O_level(level),
    .O_overflow(ovf),
    .I_clear_overflow(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int k);
    return {8'(8'h20 + k), 8'(8'h10 + k), 8'(k)};
  endfunction

  function automatic logic [7:0] elem(input logic [DW-1:0] d, input int c, input int i);
    return d[(c*BS+i)*CW +: CW];
  endfunction

  // Reference model: committed batches in a queue, partial batch in an array.
  typedef struct {
    logic [DW-1:0] data;
    int            fill;
  } batch_t;

  batch_t     mq[$];
  logic [7:0] part[CH][BS];
  int         n_m;
  bit         ovf_m, flush_prev_m, rdy_m, acc_m, fe_m, pop_m;

  function automatic batch_t make_batch(input int f);
    batch_t b;
    b.fill = f;
    b.data = '0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < BS; i++)
        b.data[(c*BS+i)*CW +: CW] = (i < f) ? part[c][i] : PAD;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      n_m = 0;
      ovf_m = 1'b0;
      flush_prev_m = 1'b0;
    end else begin
      rdy_m = (mq.size() < DP);
      acc_m = pvalid && rdy_m;
      fe_m  = flush && !flush_prev_m;
      pop_m = (mq.size() != 0) && bready;
      flush_prev_m = flush;
      if (pvalid && !rdy_m) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      if (pop_m) void'(mq.pop_front());
      if (acc_m) begin
        for (int c = 0; c < CH; c++) part[c][n_m] = pixel[c*CW +: CW];
        n_m++;
      end
      if (n_m == BS) begin
        mq.push_back(make_batch(BS));
        n_m = 0;
      end else if (fe_m && n_m != 0) begin
        mq.push_back(make_batch(n_m));
        n_m = 0;
      end
    end
  end

  bit check_en = 1'b0;
  bit mon_lvl  = 1'b0;
  int max_lvl  = 0;

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("pixel_ready", DW'(pready), DW'(mq.size() < DP));
      chk("batch_valid", DW'(bvalid), DW'(mq.size() != 0));
      chk("level", DW'(level), DW'(mq.size()));
      chk("overflow", DW'(ovf), DW'(ovf_m));
      chk("batch_fill", DW'(bfill), (mq.size() != 0) ? DW'(mq[0].fill) : '0);
      chk("batch_data", bdata, (mq.size() != 0) ? mq[0].data : '0);
      if (mon_lvl && int'(level) > max_lvl) max_lvl = int'(level);
    end
  end

  // Inputs change 1 time unit after the rising edge; return after the next one.
  task automatic drive(input bit v, input logic [23:0] p, input bit f, input bit br,
                       input bit cl);
    pvalid = v;
    pixel  = p;
    flush  = f;
    bready = br;
    clr    = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; pixel = '0; pvalid = 1'b0; bready = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("reset_ready", DW'(pready), DW'(1));
    chk("reset_valid", DW'(bvalid), DW'(0));
    chk("reset_level", DW'(level), DW'(0));

    // Full batch of 8 pixels.
    for (int k = 0; k < 8; k++) drive(1, pix(k), 0, 0, 0);
    chk("t1_valid", DW'(bvalid), DW'(1));
    chk("t1_fill", DW'(bfill), DW'(8));
    chk("t1_r3", DW'(elem(bdata, 0, 3)), DW'(8'h03));
    chk("t1_b7", DW'(elem(bdata, 2, 7)), DW'(8'h27));
    drive(0, '0, 0, 1, 0);

    // Three pixels then a flush; held flush and idle flush add nothing.
    for (int k = 0; k < 3; k++) drive(1, pix(k), 0, 0, 0);
    drive(0, '0, 1, 0, 0);
    chk("t2_fill", DW'(bfill), DW'(3));
    chk("t2_level", DW'(level), DW'(1));
    chk("t2_g2", DW'(elem(bdata, 1, 2)), DW'(8'h12));
    chk("t2_r3_pad", DW'(elem(bdata, 0, 3)), DW'(PAD));
    chk("t2_b7_pad", DW'(elem(bdata, 2, 7)), DW'(PAD));
    drive(0, '0, 1, 1, 0);
    drive(0, '0, 1, 0, 0);
    chk("t2_held_level", DW'(level), DW'(0));
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 1, 0, 0);
    chk("t2_idle_flush_level", DW'(level), DW'(0));
    drive(0, '0, 0, 0, 0);

    // Flush together with accept #5.
    for (int k = 0; k < 4; k++) drive(1, pix(k), 0, 0, 0);
    drive(1, pix(4), 1, 0, 0);
    chk("t3_fill", DW'(bfill), DW'(5));
    chk("t3_r4", DW'(elem(bdata, 0, 4)), DW'(8'h04));
    chk("t3_b4", DW'(elem(bdata, 2, 4)), DW'(8'h24));
    chk("t3_r5_pad", DW'(elem(bdata, 0, 5)), DW'(PAD));
    chk("t3_g7_pad", DW'(elem(bdata, 1, 7)), DW'(PAD));
    drive(0, '0, 0, 1, 0);

    // Fill all four slots, overflow, then drain.
    for (int k = 0; k < 32; k++) drive(1, pix(k), 0, 0, 0);
    chk("t4_level_full", DW'(level), DW'(4));
    chk("t4_ready_low", DW'(pready), DW'(0));
    chk("t4_no_ovf_yet", DW'(ovf), DW'(0));
    drive(1, pix(32), 0, 0, 0);
    chk("t4_ovf_set", DW'(ovf), DW'(1));
    chk("t4_head_r0", DW'(elem(bdata, 0, 0)), DW'(8'h00));
    drive(0, '0, 0, 1, 0);
    chk("t4_ready_back", DW'(pready), DW'(1));
    chk("t4_level_3", DW'(level), DW'(3));
    chk("t4_head2_r0", DW'(elem(bdata, 0, 0)), DW'(8'h08));
    repeat (3) drive(0, '0, 0, 1, 0);
    chk("t4_drained", DW'(level), DW'(0));
    drive(0, '0, 0, 0, 1);
    chk("t4_ovf_clear", DW'(ovf), DW'(0));

    // Streaming with an always-ready consumer.
    mon_lvl = 1'b1;
    for (int k = 0; k < 64; k++) drive(1, pix(k), 0, 1, 0);
    drive(0, '0, 0, 1, 0);
    mon_lvl = 1'b0;
    chk("t5_max_level", DW'(max_lvl), DW'(1));
    chk("t5_no_ovf", DW'(ovf), DW'(0));

    // Reset mid-batch with two batches queued.
    for (int k = 0; k < 21; k++) drive(1, pix(k), 0, 0, 0);
    chk("t6_level_pre", DW'(level), DW'(2));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", DW'(pready), DW'(1));
    chk("t6_rst_valid", DW'(bvalid), DW'(0));
    chk("t6_rst_data", bdata, '0);
    chk("t6_rst_fill", DW'(bfill), DW'(0));
    chk("t6_rst_level", DW'(level), DW'(0));
    chk("t6_rst_ovf", DW'(ovf), DW'(0));
    pvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 40; k < 48; k++) drive(1, pix(k), 0, 0, 0);
    chk("t6_fill", DW'(bfill), DW'(8));
    chk("t6_level", DW'(level), DW'(1));
    chk("t6_r0", DW'(elem(bdata, 0, 0)), DW'(8'h28));
    chk("t6_g7", DW'(elem(bdata, 1, 7)), DW'(8'h3F));
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 0, 0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
